bus_packet_mcfifo: RTL and testbench
====================================

BUS_PACKET_MCFIFO -- requirements
Module: bus_packet_mcfifo

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL have parameter DATA_W, default 64, meaning packet width in bits.
REQ-003 SHALL have parameter DEPTH, default 8, meaning entries per channel; power of two, >=2.
REQ-004 SHALL have parameter NUM_CH, default 4, meaning number of independent channels.
REQ-005 SHALL have parameter AFULL_TH, default DEPTH-2, meaning almost-full threshold in entries.
REQ-006 SHALL have ports as follows; CW = clog2(DEPTH)+1:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wr_en  in  NUM_CH  per-channel push request
- wr_data  in  NUM_CH*DATA_W  push packets; channel c at bits [c*DATA_W +: DATA_W]
- rd_en  in  NUM_CH  per-channel pop request
- flush  in  NUM_CH  per-channel discard of all contents
- err_clr  in  1  clears sticky error flags
- rd_data  out  NUM_CH*DATA_W  registered popped packets
- rd_valid  out  NUM_CH  rd_data channel c valid this cycle
- full  out  NUM_CH  count==DEPTH
- empty  out  NUM_CH  count==0
- afull  out  NUM_CH  count>=AFULL_TH
- count  out  NUM_CH*CW  occupancy per channel
- hwm  out  NUM_CH*CW  occupancy high-water mark per channel
- overflow_err  out  NUM_CH  sticky: push refused
- underflow_err  out  NUM_CH  sticky: pop refused

Function
REQ-007 SHALL operate channels independently; no event on channel c affects another channel.
REQ-008 SHALL accept a push when wr_en and (not full or rd_en accepted same cycle); data written at wr_ptr, wr_ptr advances modulo DEPTH.
REQ-009 SHALL accept a pop when rd_en and not empty; rd_data loads entry at rd_ptr next cycle, rd_valid=1 for exactly that cycle, rd_ptr advances modulo DEPTH.
REQ-010 SHALL hold rd_data at its last value when no pop is accepted; rd_valid=0.
REQ-011 SHALL update count: +1 push only, -1 pop only, unchanged when both or neither accepted.
REQ-012 Full with push+pop same cycle: both accepted, count stays DEPTH, no overflow_err.
REQ-013 Empty with push+pop same cycle: push accepted, pop refused, count becomes 1, rd_valid=0, underflow_err set.
REQ-014 SHALL set overflow_err[c] on refused push and underflow_err[c] on refused pop; stays set until err_clr or rst.
REQ-015 err_clr and a new error same cycle: error flag SHALL end set.
REQ-016 full, empty, afull SHALL be combinational from registered count.
REQ-017 hwm[c] SHALL update to next count when next count exceeds hwm; never decreases except on rst.
REQ-018 flush[c] SHALL set count, wr_ptr, rd_ptr to 0 next cycle; overrides same-cycle wr_en/rd_en on that channel (no error, no rd_valid); hwm and error flags unchanged.
REQ-019 Read latency SHALL be 1 cycle from accepted rd_en to rd_valid; write-to-readable latency 1 cycle (empty deasserts cycle after push).

Reset
REQ-020 On rst all channels: count=0, ptrs=0, hwm=0, rd_data=0, rd_valid=0, errors=0, empty=1, full=0, afull=0; memory contents need not be reset.
REQ-021 rst SHALL override flush, err_clr and all requests; asserted mid-operation discards all queued packets.

Verification
REQ-022 NUM_CH=2, DEPTH=4, DATA_W=8: push 0x11,0x22,0x33 on ch0, pop 3 -> rd_data 0x11,0x22,0x33 on consecutive rd_valid cycles; ch1 empty throughout.
REQ-023 Fill ch0 with 4 pushes, 5th push alone -> full=1, overflow_err[0]=1, count=4; then push+pop same cycle -> count=4, no new error, oldest packet out.
REQ-024 Empty ch1, push 0xAA and pop same cycle -> rd_valid[1]=0, underflow_err[1]=1, count=1; next pop -> 0xAA.
REQ-025 Push 6, pop 6 interleaved across wrap-around -> order preserved, hwm reflects peak (e.g. 3), afull asserted at count>=2.
REQ-026 ch0 count=3, flush[0] with wr_en[0] same cycle -> count=0, empty=1, hwm=3 retained, no error.
REQ-027 rst asserted with ch0 count=2 and errors set -> all outputs at REQ-020 values next cycle.

Source files
------------

// File: rtl/bus_packet_mcfifo.sv
// Multi-channel packet FIFO: NUM_CH independent queues with occupancy, high-water mark and sticky error flags.
// Read data is registered, one cycle after the pop is accepted; a full channel still takes a push if it pops in the same cycle.
module bus_packet_mcfifo #(
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 8,
    parameter int NUM_CH   = 4,
    parameter int AFULL_TH = DEPTH - 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_CH-1:0]                      wr_en,
    input  logic [NUM_CH*DATA_W-1:0]               wr_data,
    input  logic [NUM_CH-1:0]                      rd_en,
    input  logic [NUM_CH-1:0]                      flush,
    input  logic                                   err_clr,
    output logic [NUM_CH*DATA_W-1:0]               rd_data,
    output logic [NUM_CH-1:0]                      rd_valid,
    output logic [NUM_CH-1:0]                      full,
    output logic [NUM_CH-1:0]                      empty,
    output logic [NUM_CH-1:0]                      afull,
    output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]    count,
    output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]    hwm,
    output logic [NUM_CH-1:0]                      overflow_err,
    output logic [NUM_CH-1:0]                      underflow_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_TH);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_W-1:0] mem_q [DEPTH];
        logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
        logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
        logic [CW-1:0]     count_q, count_d;
        logic [CW-1:0]     hwm_q, hwm_d;
        logic [DATA_W-1:0] rd_data_q, rd_data_d;
        logic              rd_valid_q;
        logic              ovf_q, ovf_d;
        logic              udf_q, udf_d;
        logic              push_req, pop_req, push_ok, pop_ok;

        // Flush wins over requests on its own channel and raises no errors.
        always_comb begin
            push_req  = wr_en[c] & ~flush[c];
            pop_req   = rd_en[c] & ~flush[c];
            pop_ok    = pop_req & (count_q != '0);
            push_ok   = push_req & ((count_q != DEPTH_C) | pop_ok);
            wr_ptr_d  = wr_ptr_q;
            rd_ptr_d  = rd_ptr_q;
            count_d   = count_q;
            rd_data_d = rd_data_q;
            if (flush[c]) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
            end else begin
                if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
                if (pop_ok) begin
                    rd_ptr_d  = rd_ptr_q + PW'(1);
                    rd_data_d = mem_q[rd_ptr_q];
                end
                if (push_ok && !pop_ok) count_d = count_q + CW'(1);
                else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
            end
            hwm_d = (count_d > hwm_q) ? count_d : hwm_q;
            ovf_d = (push_req & ~push_ok) | (ovf_q & ~err_clr);
            udf_d = (pop_req & ~pop_ok) | (udf_q & ~err_clr);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
                hwm_q      <= '0;
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
                ovf_q      <= 1'b0;
                udf_q      <= 1'b0;
            end else begin
                wr_ptr_q   <= wr_ptr_d;
                rd_ptr_q   <= rd_ptr_d;
                count_q    <= count_d;
                hwm_q      <= hwm_d;
                rd_data_q  <= rd_data_d;
                rd_valid_q <= pop_ok;
                ovf_q      <= ovf_d;
                udf_q      <= udf_d;
            end
        end

        // Storage is not reset; the pointers and count define what is valid.
        always_ff @(posedge clk) begin
            if (!rst && !flush[c] && push_ok) mem_q[wr_ptr_q] <= wr_data[c*DATA_W +: DATA_W];
        end

        assign rd_data[c*DATA_W +: DATA_W] = rd_data_q;
        assign rd_valid[c]                 = rd_valid_q;
        assign full[c]                     = (count_q == DEPTH_C);
        assign empty[c]                    = (count_q == '0);
        assign afull[c]                    = (count_q >= AFULL_C);
        assign count[c*CW +: CW]           = count_q;
        assign hwm[c*CW +: CW]             = hwm_q;
        assign overflow_err[c]             = ovf_q;
        assign underflow_err[c]            = udf_q;
    end

endmodule

// File: tb/tb_bus_packet_mcfifo.sv
// Directed bench for bus_packet_mcfifo with NUM_CH=2, DEPTH=4, DATA_W=8.
module tb_bus_packet_mcfifo;
    localparam int DW = 8;
    localparam int NC = 2;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [NC-1:0]   wr_en, rd_en, flush;
    logic [NC*DW-1:0] wr_data;
    logic            err_clr;
    logic [NC*DW-1:0] rd_data;
    logic [NC-1:0]   rd_valid, full, empty, afull, overflow_err, underflow_err;
    logic [NC*CW-1:0] count, hwm;

    int total = 0;
    int bad   = 0;

    bus_packet_mcfifo #(.DATA_W(DW), .DEPTH(4), .NUM_CH(NC), .AFULL_TH(2)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .flush(flush), .err_clr(err_clr), .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .empty(empty), .afull(afull), .count(count), .hwm(hwm),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [1:0] we, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [1:0] re, input logic [1:0] fl, input logic ec);
        wr_en   = we;
        wr_data = {d1, d0};
        rd_en   = re;
        flush   = fl;
        err_clr = ec;
        @(posedge clk);
        #1;
        wr_en   = '0;
        rd_en   = '0;
        flush   = '0;
        err_clr = 1'b0;
    endtask

    task automatic chk_pop(input string tag, input int ch, input logic [7:0] exp);
        chk({tag, "_vld"}, 32'(rd_valid[ch]), 32'd1);
        chk({tag, "_dat"}, 32'(rd_data[ch*DW +: DW]), 32'(exp));
    endtask

    initial begin
        rst = 1'b1; wr_en = '0; rd_en = '0; flush = '0; err_clr = 1'b0; wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", 32'(empty), 32'h3);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_afull", 32'(afull), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_hwm", 32'(hwm), 32'h0);
        chk("rst_rdv", 32'(rd_valid), 32'h0);
        chk("rst_rdd", 32'(rd_data), 32'h0);
        chk("rst_err", 32'({overflow_err, underflow_err}), 32'h0);
        rst = 1'b0;

        // Three pushes then three pops on ch0.
        cyc(2'b01, 8'h11, 8'h00, 2'b00, 2'b00, 1'b0);
        chk("p1_empty", 32'(empty), 32'h2);
        chk("p1_afull", 32'(afull[0]), 32'd0);
        cyc(2'b01, 8'h22, 8'h00, 2'b00, 2'b00, 1'b0);
        chk("p2_afull", 32'(afull[0]), 32'd1);
        cyc(2'b01, 8'h33, 8'h00, 2'b00, 2'b00, 1'b0);
        chk("p3_count", 32'(count), 32'h03);
        cyc(2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 1'b0);
        chk_pop("pop11", 0, 8'h11);
        cyc(2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 1'b0);
        chk_pop("pop22", 0, 8'h22);
        cyc(2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 1'b0);
        chk_pop("pop33", 0, 8'h33);
        chk("ch1_empty", 32'(empty[1]), 32'd1);
        cyc(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0);
        chk("idle_rdv", 32'(rd_valid), 32'h0);
        chk("hold_rdd", 32'(rd_data[7:0]), 32'h33);
        chk("hwm3", 32'(hwm), 32'h03);

        // Fill ch0, refused push, then push+pop while full.
        for (int i = 0; i < 4; i++) cyc(2'b01, 8'hA0 + 8'(i), 8'h00, 2'b00, 2'b00, 1'b0);
        chk("fill_full", 32'(full), 32'h1);
        chk("fill_count", 32'(count), 32'h04);
        cyc(2'b01, 8'hA4, 8'h00, 2'b00, 2'b00, 1'b0);
        chk("ovf_set", 32'(overflow_err), 32'h1);
        chk("ovf_count", 32'(count), 32'h04);
        cyc(2'b01, 8'hA5, 8'h00, 2'b01, 2'b00, 1'b0);
        chk_pop("fullpp", 0, 8'hA0);
        chk("fullpp_count", 32'(count), 32'h04);
        chk("fullpp_udf", 32'(underflow_err), 32'h0);
        cyc(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b1);
        chk("errclr", 32'(overflow_err), 32'h0);
        cyc(2'b01, 8'hA6, 8'h00, 2'b00, 2'b00, 1'b1);
        chk("clr_vs_set", 32'(overflow_err), 32'h1);
        cyc(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b1);
        cyc(2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 1'b0);
        chk_pop("drA1", 0, 8'hA1);
        cyc(2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 1'b0);
        chk_pop("drA2", 0, 8'hA2);
        cyc(2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 1'b0);
        chk_pop("drA3", 0, 8'hA3);
        cyc(2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 1'b0);
        chk_pop("drA5", 0, 8'hA5);
        chk("dr_hwm", 32'(hwm), 32'h04);

        // Push+pop on empty ch1: only the push is taken.
        cyc(2'b10, 8'h00, 8'hAA, 2'b10, 2'b00, 1'b0);
        chk("emp_rdv", 32'(rd_valid), 32'h0);
        chk("emp_udf", 32'(underflow_err), 32'h2);
        chk("emp_count", 32'(count), 32'h08);
        cyc(2'b00, 8'h00, 8'h00, 2'b10, 2'b00, 1'b0);
        chk_pop("popAA", 1, 8'hAA);
        cyc(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 1'b1);

        // Interleaved traffic on ch1 across pointer wrap.
        cyc(2'b10, 8'h00, 8'hB1, 2'b00, 2'b00, 1'b0);
        cyc(2'b10, 8'h00, 8'hB2, 2'b00, 2'b00, 1'b0);
        chk("w_afull", 32'(afull), 32'h2);
        cyc(2'b10, 8'h00, 8'hB3, 2'b00, 2'b00, 1'b0);
        cyc(2'b10, 8'h00, 8'hB4, 2'b10, 2'b00, 1'b0);
        chk_pop("wB1", 1, 8'hB1);
        cyc(2'b10, 8'h00, 8'hB5, 2'b10, 2'b00, 1'b0);
        chk_pop("wB2", 1, 8'hB2);
        cyc(2'b10, 8'h00, 8'hB6, 2'b10, 2'b00, 1'b0);
        chk_pop("wB3", 1, 8'hB3);
        cyc(2'b00, 8'h00, 8'h00, 2'b10, 2'b00, 1'b0);
        chk_pop("wB4", 1, 8'hB4);
        cyc(2'b00, 8'h00, 8'h00, 2'b10, 2'b00, 1'b0);
        chk_pop("wB5", 1, 8'hB5);
        cyc(2'b00, 8'h00, 8'h00, 2'b10, 2'b00, 1'b0);
        chk_pop("wB6", 1, 8'hB6);
        chk("w_hwm", 32'(hwm), 32'h1C);
        chk("w_err", 32'({overflow_err, underflow_err}), 32'h0);

        // Flush ch0 at count 3 with a simultaneous push.
        for (int i = 0; i < 3; i++) cyc(2'b01, 8'hC0 + 8'(i), 8'h00, 2'b00, 2'b00, 1'b0);
        cyc(2'b01, 8'hEE, 8'h00, 2'b00, 2'b01, 1'b0);
        chk("fl_count", 32'(count), 32'h00);
        chk("fl_empty", 32'(empty), 32'h3);
        chk("fl_hwm", 32'(hwm), 32'h1C);
        chk("fl_err", 32'({overflow_err, underflow_err}), 32'h0);
        chk("fl_rdv", 32'(rd_valid), 32'h0);

        // Reset mid-operation.
        cyc(2'b01, 8'hD0, 8'h00, 2'b00, 2'b00, 1'b0);
        cyc(2'b01, 8'hD1, 8'h00, 2'b10, 2'b00, 1'b0);
        chk("pre_rst", 32'({count, underflow_err}), 32'h0A);
        rst = 1'b1;
        cyc(2'b11, 8'h55, 8'h66, 2'b11, 2'b00, 1'b1);
        rst = 1'b0;
        chk("rr_count", 32'(count), 32'h0);
        chk("rr_hwm", 32'(hwm), 32'h0);
        chk("rr_flags", 32'({empty, full, afull}), 32'h30);
        chk("rr_rd", 32'({rd_data, rd_valid}), 32'h0);
        chk("rr_err", 32'({overflow_err, underflow_err}), 32'h0);
        cyc(2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 1'b0);
        chk("rr_discard", 32'({rd_valid, underflow_err}), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
